// File: rtl/wb_ext_sram_bridge.sv
// Wishbone B3 classic 32-bit slave to 16-bit asynchronous SRAM bridge.
// Each word is split into a low then a high halfword phase. Each phase
// lasts WAIT_CYCLES+1 cycles. Every SRAM-facing output is registered.
module wb_ext_sram_bridge #(
    parameter int ADDR_WIDTH  = 27,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [2:0]            wb_cti_i,
    input  logic [1:0]            wb_bte_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic [ADDR_WIDTH-2:0] sram_addr,
    output logic [15:0]           sram_dq_o,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_lb_n,
    output logic                  sram_ub_n,
    input  logic [15:0]           sram_dq_i
);

    typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    abort_q, abort_d;
    logic [ADDR_WIDTH-1:2]   adr_q;
    logic [31:0]             dat_q;
    logic [3:0]              sel_q;
    logic                    we_q;

    logic [ADDR_WIDTH-1:2]   adr_src;
    logic [31:0]             dat_src;
    logic [3:0]              sel_src;
    logic                    we_src;
    logic                    accept;
    logic                    phase_last;
    logic                    abort_now;

    logic [ADDR_WIDTH-2:0]   addr_d;
    logic [15:0]             dq_o_d;
    logic [31:0]             dat_o_d;
    logic                    dq_oe_d, ce_d, oe_d, we_d, lb_d, ub_d, ack_d;

    // Classic-cycle only: burst tags and byte-lane address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    assign accept     = wb_cyc_i & wb_stb_i;
    assign phase_last = (cnt_q == CNT_LAST);
    // A master dropping cyc at any point of a phase cancels the rest of the word.
    assign abort_now  = abort_q | ~wb_cyc_i;

    // In IDLE the outputs for the first phase are computed from the live bus,
    // afterwards from the latched request.
    assign adr_src = (state_q == IDLE) ? wb_adr_i[ADDR_WIDTH-1:2] : adr_q;
    assign dat_src = (state_q == IDLE) ? wb_dat_i : dat_q;
    assign sel_src = (state_q == IDLE) ? wb_sel_i : sel_q;
    assign we_src  = (state_q == IDLE) ? wb_we_i  : we_q;

    // Next-state and phase counter; empty halfword phases are skipped outright.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (accept) begin
                    if (|wb_sel_i[1:0])      state_d = LO;
                    else if (|wb_sel_i[3:2]) state_d = HI;
                    else                     state_d = ACK;
                end
            end
            LO: begin
                if (phase_last) begin
                    cnt_d = 4'd0;
                    if (abort_now)         state_d = IDLE;
                    else if (|sel_q[3:2])  state_d = HI;
                    else                   state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (phase_last) begin
                    cnt_d   = 4'd0;
                    state_d = abort_now ? IDLE : ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACK: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
        abort_d = ((state_d == LO) || (state_d == HI)) ? abort_now : 1'b0;
    end

    // Next values of the registered SRAM pins, derived from the state being entered.
    always_comb begin
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        lb_d    = 1'b1;
        ub_d    = 1'b1;
        dq_oe_d = 1'b0;
        addr_d  = sram_addr;
        dq_o_d  = sram_dq_o;
        ack_d   = (state_d == ACK);
        if ((state_d == LO) || (state_d == HI)) begin
            ce_d   = 1'b0;
            addr_d = {adr_src, (state_d == HI)};
            lb_d   = (state_d == HI) ? ~sel_src[2] : ~sel_src[0];
            ub_d   = (state_d == HI) ? ~sel_src[3] : ~sel_src[1];
            if (we_src) begin
                dq_oe_d = 1'b1;
                dq_o_d  = (state_d == HI) ? dat_src[31:16] : dat_src[15:0];
                // Strobe released on the last cycle of the phase to give data hold.
                we_d    = (cnt_d == CNT_LAST);
            end else begin
                oe_d = 1'b0;
            end
        end
    end

    // Read data capture on the final cycle of a read phase; skipped halves read as zero.
    always_comb begin
        dat_o_d = wb_dat_o;
        if (!we_q && phase_last && (state_q == LO)) begin
            dat_o_d[15:0] = sram_dq_i;
            if (sel_q[3:2] == 2'b00) dat_o_d[31:16] = 16'h0000;
        end
        if (!we_q && phase_last && (state_q == HI)) begin
            dat_o_d[31:16] = sram_dq_i;
            if (sel_q[1:0] == 2'b00) dat_o_d[15:0] = 16'h0000;
        end
        if ((state_q == IDLE) && (state_d == ACK) && !wb_we_i) dat_o_d = 32'h0;
    end

    // State, counter, request latch and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            abort_q    <= 1'b0;
            adr_q      <= '0;
            dat_q      <= 32'h0;
            sel_q      <= 4'h0;
            we_q       <= 1'b0;
            wb_dat_o   <= 32'h0;
            wb_ack_o   <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= 16'h0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            if ((state_q == IDLE) && accept) begin
                adr_q <= wb_adr_i[ADDR_WIDTH-1:2];
                dat_q <= wb_dat_i;
                sel_q <= wb_sel_i;
                we_q  <= wb_we_i;
            end
            wb_dat_o   <= dat_o_d;
            wb_ack_o   <= ack_d;
            sram_addr  <= addr_d;
            sram_dq_o  <= dq_o_d;
            sram_dq_oe <= dq_oe_d;
            sram_ce_n  <= ce_d;
            sram_oe_n  <= oe_d;
            sram_we_n  <= we_d;
            sram_lb_n  <= lb_d;
            sram_ub_n  <= ub_d;
        end
    end

endmodule

// File: tb/tb_wb_ext_sram_bridge.sv
// Scoreboard bench for wb_ext_sram_bridge: stimulus queues expected acks,
// a monitor pops and compares whenever the bridge acknowledges.
module tb_wb_ext_sram_bridge;

    localparam int AW = 27;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i, wb_cyc_i, wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o, wb_err_o, wb_rty_o;
    logic [AW-2:0] sram_addr;
    logic [15:0]   sram_dq_o, sram_dq_i;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    wb_ext_sram_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n), .sram_dq_i(sram_dq_i)
    );

    typedef struct {
        int          start;
        int          lat;
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc_cnt  = 0;
    logic [15:0] mem [0:1023];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // SRAM model: asynchronous read, write committed on the rising edge of we_n.
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0000;

    always @(posedge sram_we_n) begin
        if (!sram_ce_n && sram_dq_oe) begin
            if (!sram_lb_n) mem[sram_addr[9:0]][7:0]  = sram_dq_o[7:0];
            if (!sram_ub_n) mem[sram_addr[9:0]][15:8] = sram_dq_o[15:8];
        end
    end

    // Monitor: every ack must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && wb_ack_o) begin
            check("ack_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ack_latency", 32'(cyc_cnt - e.start), 32'(e.lat));
                if (e.is_read) check("read_data", wb_dat_o, e.data);
            end
        end
    end

    task automatic drive(input logic [AW-1:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
    endtask

    task automatic release_bus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    // One transaction: queue the expected ack, then tally strobe activity until ack.
    task automatic txn(input string tag, input logic [AW-1:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we, input int lat,
                       input logic [31:0] rdata, input int exp_ce, input int exp_oe,
                       input int exp_we);
        exp_t e;
        int   n_ce, n_oe, n_we, n_lanes;
        logic seen;
        @(negedge clk);
        e.start = cyc_cnt; e.lat = lat; e.is_read = !we; e.data = rdata;
        sb_q.push_back(e);
        drive(adr, dat, sel, we);
        n_ce = 0; n_oe = 0; n_we = 0; n_lanes = 0; seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (!sram_ce_n) n_ce++;
            if (!sram_ce_n && !sram_oe_n) n_oe++;
            if (!sram_ce_n && !sram_we_n) n_we++;
            if (!sram_ce_n && !sram_lb_n && !sram_ub_n) n_lanes++;
            if (wb_ack_o) seen = 1'b1;
        end
        release_bus();
        check({tag, "_acked"}, 32'(seen), 32'd1);
        check({tag, "_ce_cycles"}, 32'(n_ce), 32'(exp_ce));
        check({tag, "_oe_cycles"}, 32'(n_oe), 32'(exp_oe));
        check({tag, "_we_cycles"}, 32'(n_we), 32'(exp_we));
        check({tag, "_lane_cycles"}, 32'(n_lanes), 32'(exp_ce));
    endtask

    initial begin : stimulus
        int   n, acks, n_ce;
        exp_t e;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h080] = 16'hBEEF;
        mem[10'h081] = 16'hDEAD;
        mem[10'h102] = 16'hAAAA;
        mem[10'h103] = 16'hBBBB;
        mem[10'h104] = 16'h1111;
        mem[10'h105] = 16'h2222;
        mem[10'h106] = 16'h3333;
        mem[10'h107] = 16'h4444;
        wb_adr_i = '0; wb_dat_i = 32'h0; wb_sel_i = 4'h0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b111; wb_bte_i = 2'b11;

        // Reset values
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat_o", wb_dat_o, 32'h0);
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1F);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_dq_o", 32'(sram_dq_o), 32'h0);
        check("err_rty", 32'({wb_err_o, wb_rty_o}), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Full word read and write, then partial-select and empty-select variants
        txn("rd_full",  27'h100, 32'h0,         4'hF, 1'b0, 7, 32'hDEADBEEF, 6, 6, 0);
        txn("wr_full",  27'h204, 32'h12345678,  4'hF, 1'b1, 7, 32'h0,        6, 0, 4);
        check("mem_102", 32'(mem[10'h102]), 32'h5678);
        check("mem_103", 32'(mem[10'h103]), 32'h1234);
        txn("wr_hi",    27'h208, 32'h9ABC5555,  4'hC, 1'b1, 4, 32'h0,        3, 0, 2);
        check("mem_104_kept", 32'(mem[10'h104]), 32'h1111);
        check("mem_105", 32'(mem[10'h105]), 32'h9ABC);
        txn("wr_none",  27'h20C, 32'hFFFFFFFF,  4'h0, 1'b1, 1, 32'h0,        0, 0, 0);
        check("mem_106_kept", 32'(mem[10'h106]), 32'h3333);
        check("mem_107_kept", 32'(mem[10'h107]), 32'h4444);
        txn("rd_lo",    27'h100, 32'h0,         4'h3, 1'b0, 4, 32'h0000BEEF, 3, 3, 0);
        txn("rd_hi",    27'h100, 32'h0,         4'hC, 1'b0, 4, 32'hDEAD0000, 3, 3, 0);
        txn("rd_none",  27'h100, 32'h0,         4'h0, 1'b0, 1, 32'h0,        0, 0, 0);
        txn("rd_wr",    27'h204, 32'h0,         4'hF, 1'b0, 7, 32'h12345678, 6, 6, 0);

        // Back-to-back reads with stb held: second ack 8 cycles after the first
        @(negedge clk);
        n = cyc_cnt;
        e.lat = 7; e.is_read = 1'b1; e.data = 32'hDEADBEEF;
        e.start = n;     sb_q.push_back(e);
        e.start = n + 8; sb_q.push_back(e);
        drive(27'h100, 32'h0, 4'hF, 1'b0);
        acks = 0;
        for (int k = 1; k <= 60 && acks < 2; k++) begin
            @(negedge clk);
            if (wb_ack_o) acks++;
        end
        release_bus();
        check("b2b_acks", 32'(acks), 32'd2);

        // Master drops cyc in cycle 2 of a read: LO finishes, HI never starts
        @(negedge clk);
        drive(27'h100, 32'h0, 4'hF, 1'b0);
        n_ce = 0; acks = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 2) release_bus();
            if (k == 3) check("abort_c3_ce", 32'(sram_ce_n), 32'd0);
            if (k == 4) check("abort_c4_ce", 32'(sram_ce_n), 32'd1);
            if (!sram_ce_n) n_ce++;
            if (wb_ack_o) acks++;
        end
        check("abort_ce_cycles", 32'(n_ce), 32'd3);
        check("abort_no_ack", 32'(acks), 32'd0);

        // Reset asserted in the middle of a write phase
        @(negedge clk);
        drive(27'h300, 32'hFFFF0000, 4'hF, 1'b1);
        repeat (2) @(negedge clk);
        check("midwr_we_low", 32'(sram_we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midwr_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1F);
        check("midwr_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("midwr_ack", 32'(wb_ack_o), 32'd0);
        release_bus();
        repeat (2) @(negedge clk);
        check("midwr_ack_held", 32'(wb_ack_o), 32'd0);
        rst_n = 1'b1;
        txn("rd_after_rst", 27'h100, 32'h0, 4'hF, 1'b0, 7, 32'hDEADBEEF, 6, 6, 0);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
